// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port memory: a data port with fixed
// priority and an instruction-fetch port protected by a starvation counter.
// At most one memory transaction is outstanding at a time.

package mem_arbiter_pkg;
    typedef enum logic [2:0] {
        MEM_LB,
        MEM_LH,
        MEM_LW,
        MEM_LBU,
        MEM_LHU,
        MEM_SB,
        MEM_SH,
        MEM_SW
    } mem_op_t;
endpackage

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter mem_op_t     IF_OP        = MEM_LW
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  mem_op_t     d_op,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output mem_op_t     mem_op,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic { S_IDLE, S_BUSY } state_t;
    typedef enum logic { OWN_D, OWN_IF } owner_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    mem_op_t     op_q, op_d;
    logic        we_q, we_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        pick_if;

    // Arbitration, payload capture, completion and starvation tracking
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        op_d         = op_q;
        we_d         = we_q;
        starve_cnt_d = starve_cnt_q;
        if_gnt       = 1'b0;
        d_gnt        = 1'b0;
        if_rvalid    = 1'b0;
        d_rvalid     = 1'b0;
        pick_if      = if_req && (!d_req || (starve_cnt_q == LIMIT));

        case (state_q)
            S_IDLE: begin
                if (!reset && (if_req || d_req)) begin
                    state_d = S_BUSY;
                    if (pick_if) begin
                        if_gnt       = 1'b1;
                        owner_d      = OWN_IF;
                        addr_d       = if_addr;
                        op_d         = IF_OP;
                        we_d         = 1'b0;
                        wdata_d      = '0;
                        starve_cnt_d = '0;
                    end else begin
                        d_gnt   = 1'b1;
                        owner_d = OWN_D;
                        addr_d  = d_addr;
                        op_d    = d_op;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                        if (!if_req)
                            starve_cnt_d = '0;
                        else if (starve_cnt_q != LIMIT)
                            starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end
            end
            S_BUSY: begin
                // A reset in the completion cycle aborts; no rvalid escapes.
                if (mem_ready && !reset) begin
                    state_d = S_IDLE;
                    if (owner_q == OWN_IF)
                        if_rvalid = 1'b1;
                    else
                        d_rvalid = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and latched-transaction registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_D;
            addr_q       <= '0;
            wdata_q      <= '0;
            op_q         <= mem_op_t'(3'd0);
            we_q         <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            op_q         <= op_d;
            we_q         <= we_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign busy      = (state_q == S_BUSY);
    assign mem_req   = busy;
    assign mem_we    = busy && we_q;
    assign mem_op    = op_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single fetch, contention,
// starvation rotation, mid-transaction reset, stray ready, payload hold.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    mem_op_t     d_op;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    mem_op_t     mem_op;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;

    int unsigned passed = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(4), .IF_OP(MEM_LW)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_op(d_op), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_op(mem_op), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1; if_req = 1'b1; d_req = 1'b1; mem_ready = 1'b0;
        #1;
        total++; if (if_gnt !== 1'b0 || d_gnt !== 1'b0) $display("FAIL rst_gnt_suppress: if_gnt=%b d_gnt=%b want 0 0", if_gnt, d_gnt); else passed++;
        step(); step();
        #1;
        total++; if (busy !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0) $display("FAIL rst_state: busy=%b mem_req=%b mem_we=%b want 0 0 0", busy, mem_req, mem_we); else passed++;
        total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_op !== MEM_LB) $display("FAIL rst_mem_bus: addr=%h wdata=%h op=%0d want 0 0 0", mem_addr, mem_wdata, mem_op); else passed++;
        total++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || if_rdata !== 32'h0 || d_rdata !== 32'h0) $display("FAIL rst_rvalid: if_rv=%b d_rv=%b", if_rvalid, d_rvalid); else passed++;
        reset = 1'b0; if_req = 1'b0; d_req = 1'b0;
        step();
    endtask

    task automatic test_single_fetch();
        if_req = 1'b1; if_addr = 32'h100;
        #1;
        total++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_req !== 1'b0) $display("FAIL fetch_c0: if_gnt=%b d_gnt=%b mem_req=%b want 1 0 0", if_gnt, d_gnt, mem_req); else passed++;
        step();
        if_req = 1'b0; if_addr = 32'hFFFF_FFF0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin mem_ready = 1'b1; mem_rdata = 32'h0050_0093; end
            #1;
            total++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_op !== MEM_LW || mem_we !== 1'b0 || mem_wdata !== 32'h0) $display("FAIL fetch_bus_c%0d: req=%b addr=%h op=%0d we=%b want 1 100 %0d 0", c, mem_req, mem_addr, mem_op, mem_we, MEM_LW); else passed++;
            total++; if (if_rvalid !== (c == 3) || if_rdata !== ((c == 3) ? 32'h0050_0093 : 32'h0)) $display("FAIL fetch_rvalid_c%0d: rvalid=%b rdata=%h", c, if_rvalid, if_rdata); else passed++;
            step();
        end
        mem_ready = 1'b0; mem_rdata = 32'h0;
        #1;
        total++; if (busy !== 1'b0 || if_rvalid !== 1'b0) $display("FAIL fetch_done: busy=%b rvalid=%b want 0 0", busy, if_rvalid); else passed++;
        step();
    endtask

    task automatic test_contention();
        if_req = 1'b1; if_addr = 32'h140;
        d_req = 1'b1; d_we = 1'b1; d_op = MEM_SW; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
        #1;
        total++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) $display("FAIL cont_first: d_gnt=%b if_gnt=%b want 1 0", d_gnt, if_gnt); else passed++;
        step();
        d_req = 1'b0; d_we = 1'b0; d_wdata = 32'h0;
        #1;
        total++; if (mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h200 || mem_op !== MEM_SW) $display("FAIL cont_write: we=%b wdata=%h addr=%h op=%0d", mem_we, mem_wdata, mem_addr, mem_op); else passed++;
        total++; if (if_gnt !== 1'b0) $display("FAIL cont_busy_gnt: if_gnt=%b want 0", if_gnt); else passed++;
        step();
        mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        #1;
        total++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h1234_5678 || if_rvalid !== 1'b0) $display("FAIL cont_rvalid: d_rvalid=%b d_rdata=%h if_rvalid=%b", d_rvalid, d_rdata, if_rvalid); else passed++;
        total++; if (if_gnt !== 1'b0 || d_gnt !== 1'b0) $display("FAIL cont_ready_nogrant: if_gnt=%b d_gnt=%b want 0 0", if_gnt, d_gnt); else passed++;
        step();
        mem_ready = 1'b0;
        #1;
        total++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0) $display("FAIL cont_fetch_next: if_gnt=%b want 1", if_gnt); else passed++;
        step();
        if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hA5A5_0001;
        #1;
        total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hA5A5_0001 || mem_addr !== 32'h140) $display("FAIL cont_fetch_done: rvalid=%b rdata=%h addr=%h", if_rvalid, if_rdata, mem_addr); else passed++;
        step();
        mem_ready = 1'b0; mem_rdata = 32'h0;
        step();
    endtask

    task automatic test_starvation();
        logic exp_if;
        logic last_if;
        int unsigned k;
        last_if = 1'b0;
        if_req = 1'b1; if_addr = 32'h400;
        d_req = 1'b1; d_we = 1'b0; d_op = MEM_LW; d_addr = 32'h800;
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_0000;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (i % 2 == 0) begin
                k = i / 2;
                exp_if = ((k % 5) == 4);
                total++; if (if_gnt !== exp_if || d_gnt !== !exp_if) $display("FAIL starve_grant%0d: if_gnt=%b d_gnt=%b want %b %b", k, if_gnt, d_gnt, exp_if, !exp_if); else passed++;
                last_if = exp_if;
            end else begin
                total++; if (if_rvalid !== last_if || d_rvalid !== !last_if || if_gnt !== 1'b0 || d_gnt !== 1'b0) $display("FAIL starve_done%0d: if_rv=%b d_rv=%b gnts=%b%b", i / 2, if_rvalid, d_rvalid, if_gnt, d_gnt); else passed++;
            end
            step();
        end
        if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
        #1;
        total++; if (busy !== 1'b0 || dut.starve_cnt_q !== 4'd0) $display("FAIL starve_end: busy=%b cnt=%0d want 0 0", busy, dut.starve_cnt_q); else passed++;
        step();
    endtask

    task automatic test_reset_mid();
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_op = MEM_LH; d_addr = 32'h600;
        #1;
        total++; if (d_gnt !== 1'b1) $display("FAIL rmid_gnt: d_gnt=%b want 1", d_gnt); else passed++;
        step();
        if_req = 1'b0; d_req = 1'b0;
        #1;
        total++; if (dut.starve_cnt_q !== 4'd1 || busy !== 1'b1) $display("FAIL rmid_pre: cnt=%0d busy=%b want 1 1", dut.starve_cnt_q, busy); else passed++;
        reset = 1'b1;
        step();
        reset = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
        #1;
        total++; if (mem_req !== 1'b0 || busy !== 1'b0 || d_rvalid !== 1'b0 || dut.starve_cnt_q !== 4'd0) $display("FAIL rmid_after: mem_req=%b busy=%b d_rvalid=%b cnt=%0d want 0 0 0 0", mem_req, busy, d_rvalid, dut.starve_cnt_q); else passed++;
        step();
        mem_ready = 1'b0;
        step();
    endtask

    task automatic test_stray_ready();
        mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || busy !== 1'b0 || d_rdata !== 32'h0 || if_rdata !== 32'h0) $display("FAIL stray%0d: if_rv=%b d_rv=%b busy=%b", i, if_rvalid, d_rvalid, busy); else passed++;
            step();
        end
        mem_ready = 1'b0; mem_rdata = 32'h0;
    endtask

    task automatic test_payload_hold();
        d_req = 1'b1; d_we = 1'b1; d_op = MEM_SW; d_addr = 32'h300; d_wdata = 32'h1111_1111;
        #1;
        total++; if (d_gnt !== 1'b1) $display("FAIL hold_gnt: d_gnt=%b want 1", d_gnt); else passed++;
        step();
        d_req = 1'b0; d_we = 1'b0; d_op = MEM_LB; d_addr = 32'h3FC; d_wdata = 32'h2222_2222;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) mem_ready = 1'b1;
            #1;
            total++; if (mem_addr !== 32'h300 || mem_wdata !== 32'h1111_1111 || mem_we !== 1'b1 || mem_op !== MEM_SW) $display("FAIL hold_c%0d: addr=%h wdata=%h we=%b op=%0d", c, mem_addr, mem_wdata, mem_we, mem_op); else passed++;
            step();
        end
        mem_ready = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || mem_we !== 1'b0) $display("FAIL hold_end: busy=%b mem_we=%b want 0 0", busy, mem_we); else passed++;
    endtask

    initial begin
        reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_op = MEM_LB; d_addr = '0; d_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
        test_reset();
        test_single_fetch();
        test_contention();
        test_starvation();
        test_reset_mid();
        test_stray_ready();
        test_payload_hold();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: the maximum number of consecutive data grants while an instruction-fetch request is waiting; legal range 1..15.
REQ-002 SHALL have parameter IF_OP, type mem_op_t, default MEM_LW: the memory operation driven for every instruction-fetch transaction.
REQ-003 SHALL have the following ports, one per line: name  direction  width  meaning.
  - clk  in  1  single clock; all state updates on its rising edge.
  - reset  in  1  synchronous, active-high reset.
  - if_req  in  1  instruction-fetch read request.
  - if_addr  in  32  fetch address.
  - if_gnt  out  1  fetch request accepted this cycle.
  - if_rvalid  out  1  fetch data valid, one-cycle pulse.
  - if_rdata  out  32  fetch data.
  - d_req  in  1  data-port request.
  - d_we  in  1  data-port write enable.
  - d_op  in  mem_op_t  data-port operation.
  - d_addr  in  32  data-port address.
  - d_wdata  in  32  data-port write data.
  - d_gnt  out  1  data request accepted this cycle.
  - d_rvalid  out  1  data transaction complete (reads and writes), one-cycle pulse.
  - d_rdata  out  32  data-port read data.
  - mem_req  out  1  request to the shared single-port memory.
  - mem_we  out  1  memory write enable.
  - mem_op  out  mem_op_t  memory operation.
  - mem_addr  out  32  memory address.
  - mem_wdata  out  32  memory write data.
  - mem_ready  in  1  memory completes the current transaction this cycle.
  - mem_rdata  in  32  memory read data, valid when mem_ready=1.
  - busy  out  1  a transaction is outstanding.

Function
REQ-004 SHALL implement a two-state FSM, IDLE and BUSY, with at most one outstanding memory transaction.
REQ-005 In IDLE with at least one request, SHALL assert exactly one grant combinationally in that cycle, latch the owner, address, op, we and wdata, and enter BUSY on the next edge.
REQ-006 Arbitration SHALL give the data port fixed priority, except that when both ports request and starve_cnt == STARVE_LIMIT, the fetch port SHALL be granted.
REQ-007 starve_cnt (4 bits) SHALL increment on a data grant made while if_req=1, SHALL clear on any fetch grant or on a data grant made while if_req=0, and SHALL saturate at STARVE_LIMIT.
REQ-008 In BUSY, mem_req SHALL be 1 and mem_we, mem_op, mem_addr and mem_wdata SHALL hold the latched values, stable until mem_ready.
REQ-009 In IDLE, mem_req SHALL be 0 and mem_we SHALL be 0; the other mem_* outputs are don't-care.
REQ-010 For a fetch transaction, the latched op SHALL be IF_OP, mem_we SHALL be 0 and mem_wdata SHALL be 0.
REQ-011 mem_ready SHALL be sampled only in BUSY; mem_ready in IDLE SHALL be ignored.
REQ-012 On mem_ready in BUSY, the owner's rvalid SHALL pulse for exactly that cycle, the owner's rdata SHALL equal mem_rdata combinationally, and the FSM SHALL return to IDLE.
REQ-013 No grant SHALL be issued in the cycle mem_ready completes a transaction, so the minimum transaction period is 2 cycles (grant cycle plus ready cycle).
REQ-014 if_rdata and d_rdata SHALL be 0 whenever their rvalid is 0.
REQ-015 if_gnt, d_gnt, if_rvalid and d_rvalid SHALL never be asserted in the same cycle as one another.
REQ-016 busy SHALL equal (state == BUSY).
REQ-017 A request deasserted after its grant SHALL NOT cancel the transaction.
REQ-018 Requesters SHALL hold req and its payload until gnt; the arbiter does not buffer an unaccepted request.

Reset
REQ-019 While reset=1 at a clock edge, the block SHALL enter IDLE, clear starve_cnt and the latched owner, address and data; all outputs SHALL then be 0.
REQ-020 Reset asserted during BUSY SHALL abort the transaction: mem_req SHALL be 0 after that edge and no rvalid SHALL be issued for the aborted transaction.
REQ-021 Grants SHALL be suppressed in any cycle where reset=1.

Verification
REQ-022 Single fetch: if_req=1, if_addr=0x100, mem_ready asserted 3 cycles after grant, mem_rdata=0x00500093 -> if_gnt in cycle 0; mem_addr=0x100 and mem_op=IF_OP for cycles 1-3; if_rvalid with if_rdata=0x00500093 in cycle 3 only.
REQ-023 Contention: if_req=d_req=1 together, d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF -> d_gnt first, mem_we=1 with 0xDEADBEEF at 0x200; if_gnt in the first IDLE cycle after d_rvalid.
REQ-024 Starvation: STARVE_LIMIT=4, if_req and d_req held high, mem_ready=1 every BUSY cycle -> grant order D,D,D,D,I,D,D,D,D,I; a new grant every 2 cycles.
REQ-025 Reset mid-transaction: d_req granted, reset=1 for 1 cycle while BUSY with mem_ready=0 -> mem_req=0 the next cycle, no d_rvalid, busy=0, starve_cnt=0.
REQ-026 Stray ready: mem_ready=1 in IDLE with no request -> no rvalid pulse and the state stays IDLE.
REQ-027 Payload hold: in BUSY, change d_addr and d_wdata on the input side -> mem_addr and mem_wdata remain at the latched values until mem_ready.
